button_event_queue: RTL

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

---
 rtl/button_event_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - collects one-cycle button pulses into a pending
// set and queues them, lowest index first, into a first-word-fall-through FIFO.
module button_event_queue #(
    parameter  int FIELDS = 4,
    parameter  int DEPTH  = 8,
    localparam int ID_W   = (FIELDS > 1) ? $clog2(FIELDS) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [FIELDS-1:0] pulses_in,
    output logic              event_valid_out,
    input  logic              event_ready_in,
    output logic [ID_W-1:0]   event_id_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow_out,
    input  logic              clear_overflow_in,
    output logic [7:0]        drop_count_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FIELDS-1:0] pending_q, pending_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_count_q, drop_count_d;
    logic [ID_W-1:0]   mem_q [DEPTH];

    logic              pop;
    logic              push;
    logic [ID_W-1:0]   push_id;
    logic [FIELDS-1:0] push_mask;
    logic [FIELDS-1:0] drops;
    logic [4:0]        drop_n;
    logic [8:0]        drop_base;
    logic [8:0]        drop_sum;

    always_comb begin
        pop  = (count_q != '0) && event_ready_in;
        push = (pending_q != '0) && ((count_q < CNT_W'(DEPTH)) || pop);

        // Scan downward so the lowest set index is the one left standing.
        push_id = '0;
        for (int i = FIELDS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_id = ID_W'(i);
            end
        end
        push_mask = push ? (FIELDS'(1) << push_id) : '0;

        // A pulse on the bit leaving this cycle re-arms it instead of dropping.
        drops     = pulses_in & pending_q & ~push_mask;
        pending_d = (pending_q & ~push_mask) | pulses_in;

        drop_n = '0;
        for (int i = 0; i < FIELDS; i++) begin
            drop_n = drop_n + 5'(drops[i]);
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Drops in a clearing cycle win: the count restarts from this cycle's drops.
        drop_base = clear_overflow_in ? 9'd0 : {1'b0, drop_count_q};
        drop_sum  = drop_base + {4'b0, drop_n};
        if (drop_n != '0) begin
            overflow_d   = 1'b1;
            drop_count_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end else if (clear_overflow_in) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end else begin
            overflow_d   = overflow_q;
            drop_count_d = drop_count_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    assign event_valid_out = (count_q != '0);
    assign event_id_out    = mem_q[rd_ptr_q];
    assign count_out       = count_q;
    assign overflow_out    = overflow_q;
    assign drop_count_out  = drop_count_q;

endmodule
